// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage controller: load/store size encodings,
// byte-lane size masks, the FSM state type and the alignment check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Byte-lane mask of the access size, before shifting by the offset.
  function automatic logic [7:0] size_mask(input logic [2:0] func3);
    logic [7:0] mask;
    case (func3)
      F3_B, F3_BU: mask = 8'h01;
      F3_H, F3_HU: mask = 8'h03;
      F3_W, F3_WU: mask = 8'h0F;
      F3_D:        mask = 8'hFF;
      default:     mask = 8'h00;
    endcase
    return mask;
  endfunction

  // Encodings the datapath cannot serve are reported as misaligned too.
  function automatic logic is_misaligned(input logic [2:0] func3,
                                         input logic [2:0] off,
                                         input logic       is64);
    logic bad;
    case (func3)
      F3_B, F3_BU: bad = 1'b0;
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off[1:0] != 2'b00);
      F3_WU:       bad = is64 ? (off[1:0] != 2'b00) : 1'b1;
      F3_D:        bad = is64 ? (off != 3'b000) : 1'b1;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_extract.sv
// Load data extraction: move the addressed bytes down to bit 0, keep the
// access size and sign- or zero-extend to the full datapath width.
module load_extract
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      off,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted_s;
  logic [XLEN-1:0] keep_s;
  logic            sign_s;

  // Shift, mask to size, then extend (func3[2] set means unsigned).
  always_comb begin
    shifted_s = rdata >> {off, 3'b000};
    keep_s    = '0;
    sign_s    = 1'b0;
    case (func3)
      F3_B, F3_BU: begin
        keep_s = XLEN'(64'h0000_0000_0000_00FF);
        sign_s = shifted_s[7];
      end
      F3_H, F3_HU: begin
        keep_s = XLEN'(64'h0000_0000_0000_FFFF);
        sign_s = shifted_s[15];
      end
      F3_W, F3_WU: begin
        keep_s = XLEN'(64'h0000_0000_FFFF_FFFF);
        sign_s = shifted_s[31];
      end
      F3_D: begin
        keep_s = '1;
        sign_s = 1'b0;
      end
      default: begin
        keep_s = '0;
        sign_s = 1'b0;
      end
    endcase
    if (!func3[2] && sign_s) begin
      data = (shifted_s & keep_s) | ~keep_s;
    end else begin
      data = shifted_s & keep_s;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory accesses on a req/ready bus, holds
// the pipeline while an access is outstanding and registers MEM/WB results.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [XLEN-1:0]     in_alu_out,
  input  logic [XLEN-1:0]     in_rv2,
  input  logic [XLEN-1:0]     in_pc_imm,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [4:0]          in_rd,
  input  logic [1:0]          in_reg_in_sel,
  input  logic [2:0]          in_func3,
  input  logic                in_is_load,
  input  logic                in_is_store,
  input  logic                in_reg_wr,
  input  logic                flush,
  output logic                stall,
  output logic                dmem_req,
  output logic [XLEN/8-1:0]   dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_ready,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_valid,
  output logic [XLEN-1:0]     wb_alu_out,
  output logic [XLEN-1:0]     wb_data,
  output logic [XLEN-1:0]     wb_pc_imm,
  output logic [XLEN-1:0]     wb_imm,
  output logic [4:0]          wb_rd,
  output logic [1:0]          wb_reg_in_sel,
  output logic                wb_mem_reg,
  output logic                wb_reg_wr,
  output logic                exc_misalign,
  output logic                exc_bus
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]     TO_V       = CW'(TIMEOUT);
  localparam logic              TO_EN      = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic              IS64       = (XLEN == 64) ? 1'b1 : 1'b0;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);

  state_t state_r, state_s;
  logic [CW-1:0] count_r, count_s;

  logic [2:0]        off_s;
  logic              ld_s, st_s, mem_op_s, misalign_s;
  logic              issue_s, wait_s, timeout_s, kill_s;
  logic [ADDR_W-1:0] addr_s;
  logic [15:0]       we_wide_s;
  logic [NB-1:0]     we_s;
  logic [XLEN-1:0]   wdata_s;

  logic [ADDR_W-1:0] lat_addr_r;
  logic [NB-1:0]     lat_we_r;
  logic [XLEN-1:0]   lat_wdata_r, lat_alu_r, lat_pc_imm_r, lat_imm_r;
  logic [4:0]        lat_rd_r;
  logic [1:0]        lat_sel_r;
  logic              lat_reg_wr_r, lat_is_load_r, lat_kill_r;
  logic [2:0]        lat_off_r, lat_f3_r;

  logic [2:0]      ext_off_s, ext_f3_s;
  logic [XLEN-1:0] load_data_s;

  logic            nx_valid_s, nx_mem_reg_s, nx_reg_wr_s, nx_exc_mis_s, nx_exc_bus_s;
  logic [XLEN-1:0] nx_alu_s, nx_data_s, nx_pc_imm_s, nx_imm_s;
  logic [4:0]      nx_rd_s;
  logic [1:0]      nx_sel_s;

  // Decode the incoming slot: size/alignment, lane-aligned store data and enables.
  always_comb begin
    off_s      = 3'(in_alu_out[OB-1:0]);
    ld_s       = in_is_load & ~in_is_store;
    st_s       = in_is_store;
    mem_op_s   = in_is_load | in_is_store;
    misalign_s = is_misaligned(in_func3, off_s, IS64);
    wait_s     = (state_r == ST_WAIT);
    timeout_s  = wait_s & TO_EN & (count_r == TO_V);
    issue_s    = rst_n & (state_r == ST_IDLE) & in_valid & mem_op_s & ~misalign_s & ~flush;
    kill_s     = lat_kill_r | flush;
    addr_s     = ADDR_W'(in_alu_out) & ALIGN_MASK;
    we_wide_s  = {8'h00, size_mask(in_func3)} << off_s;
    if (st_s) begin
      we_s = we_wide_s[NB-1:0];
    end else begin
      we_s = '0;
    end
    wdata_s = in_rv2 << {off_s, 3'b000};
  end

  // Bus drive: live request on issue, latched copy while waiting, idle otherwise.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (issue_s) begin
      dmem_req   = 1'b1;
      dmem_we    = we_s;
      dmem_addr  = addr_s;
      dmem_wdata = wdata_s;
    end else if (wait_s && !timeout_s) begin
      dmem_req   = 1'b1;
      dmem_we    = lat_we_r;
      dmem_addr  = lat_addr_r;
      dmem_wdata = lat_wdata_r;
    end else begin
      dmem_req = 1'b0;
    end
    stall = (issue_s & ~dmem_ready) | (wait_s & ~timeout_s & ~dmem_ready);
  end

  // Extraction uses the live offset/size on a same-cycle hit, the latched ones when waiting.
  always_comb begin
    if (wait_s) begin
      ext_off_s = lat_off_r;
      ext_f3_s  = lat_f3_r;
    end else begin
      ext_off_s = off_s;
      ext_f3_s  = in_func3;
    end
  end

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .rdata (dmem_rdata),
    .off   (ext_off_s),
    .func3 (ext_f3_s),
    .data  (load_data_s)
  );

  // Next state, wait counter and next MEM/WB slot contents.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    nx_valid_s   = 1'b0;
    nx_mem_reg_s = 1'b0;
    nx_reg_wr_s  = 1'b0;
    nx_exc_mis_s = 1'b0;
    nx_exc_bus_s = 1'b0;
    nx_data_s    = '0;
    nx_alu_s     = in_alu_out;
    nx_pc_imm_s  = in_pc_imm;
    nx_imm_s     = in_imm;
    nx_rd_s      = in_rd;
    nx_sel_s     = in_reg_in_sel;
    case (state_r)
      ST_IDLE: begin
        count_s = '0;
        if (in_valid && !flush) begin
          if (mem_op_s && misalign_s) begin
            nx_valid_s   = 1'b1;
            nx_exc_mis_s = 1'b1;
          end else if (mem_op_s) begin
            if (dmem_ready) begin
              nx_valid_s   = 1'b1;
              nx_reg_wr_s  = ld_s & in_reg_wr;
              nx_mem_reg_s = ld_s;
              nx_data_s    = ld_s ? load_data_s : '0;
            end else begin
              state_s = ST_WAIT;
              if (TO_EN) begin
                count_s = CW'(1);
              end else begin
                count_s = '0;
              end
            end
          end else begin
            nx_valid_s  = 1'b1;
            nx_reg_wr_s = in_reg_wr;
          end
        end else begin
          nx_valid_s = 1'b0;
        end
      end
      ST_WAIT: begin
        nx_alu_s    = lat_alu_r;
        nx_pc_imm_s = lat_pc_imm_r;
        nx_imm_s    = lat_imm_r;
        nx_rd_s     = lat_rd_r;
        nx_sel_s    = lat_sel_r;
        if (timeout_s) begin
          state_s      = ST_IDLE;
          count_s      = '0;
          nx_valid_s   = ~kill_s;
          nx_exc_bus_s = 1'b1;
        end else if (dmem_ready) begin
          state_s      = ST_IDLE;
          count_s      = '0;
          nx_valid_s   = ~kill_s;
          nx_reg_wr_s  = ~kill_s & lat_reg_wr_r & lat_is_load_r;
          nx_mem_reg_s = lat_is_load_r;
          nx_data_s    = lat_is_load_r ? load_data_s : '0;
        end else begin
          if (TO_EN) begin
            count_s = count_r + CW'(1);
          end else begin
            count_s = count_r;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = '0;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      count_r <= '0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
    end
  end

  // Latched request copy; a flush while waiting only marks the slot as killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr_r    <= '0;
      lat_we_r      <= '0;
      lat_wdata_r   <= '0;
      lat_alu_r     <= '0;
      lat_pc_imm_r  <= '0;
      lat_imm_r     <= '0;
      lat_rd_r      <= 5'd0;
      lat_sel_r     <= 2'd0;
      lat_reg_wr_r  <= 1'b0;
      lat_is_load_r <= 1'b0;
      lat_kill_r    <= 1'b0;
      lat_off_r     <= 3'd0;
      lat_f3_r      <= 3'd0;
    end else if (issue_s) begin
      lat_addr_r    <= addr_s;
      lat_we_r      <= we_s;
      lat_wdata_r   <= wdata_s;
      lat_alu_r     <= in_alu_out;
      lat_pc_imm_r  <= in_pc_imm;
      lat_imm_r     <= in_imm;
      lat_rd_r      <= in_rd;
      lat_sel_r     <= in_reg_in_sel;
      lat_reg_wr_r  <= in_reg_wr;
      lat_is_load_r <= ld_s;
      lat_kill_r    <= 1'b0;
      lat_off_r     <= off_s;
      lat_f3_r      <= in_func3;
    end else if (wait_s && flush) begin
      lat_kill_r <= 1'b1;
    end
  end

  // MEM/WB output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_alu_out    <= '0;
      wb_data       <= '0;
      wb_pc_imm     <= '0;
      wb_imm        <= '0;
      wb_rd         <= 5'd0;
      wb_reg_in_sel <= 2'd0;
      wb_mem_reg    <= 1'b0;
      wb_reg_wr     <= 1'b0;
      exc_misalign  <= 1'b0;
      exc_bus       <= 1'b0;
    end else begin
      wb_valid      <= nx_valid_s;
      wb_alu_out    <= nx_alu_s;
      wb_data       <= nx_data_s;
      wb_pc_imm     <= nx_pc_imm_s;
      wb_imm        <= nx_imm_s;
      wb_rd         <= nx_rd_s;
      wb_reg_in_sel <= nx_sel_s;
      wb_mem_reg    <= nx_mem_reg_s;
      wb_reg_wr     <= nx_reg_wr_s;
      exc_misalign  <= nx_exc_mis_s;
      exc_bus       <= nx_exc_bus_s;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a 32-bit instance with a short timeout
// and a 64-bit instance for the wide load/store lanes.
module tb_mem_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid, in_is_load, in_is_store, in_reg_wr, flush;
  logic [31:0] in_alu_out, in_rv2, in_pc_imm, in_imm;
  logic [4:0]  in_rd;
  logic [1:0]  in_reg_in_sel;
  logic [2:0]  in_func3;
  logic        stall, dmem_req, dmem_ready;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_mem_reg, wb_reg_wr, exc_misalign, exc_bus;
  logic [31:0] wb_alu_out, wb_data, wb_pc_imm, wb_imm;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_reg_in_sel;

  logic        in_valid_64, in_is_load_64, in_is_store_64, in_reg_wr_64, flush_64;
  logic [63:0] in_alu_out_64, in_rv2_64, in_pc_imm_64, in_imm_64;
  logic [4:0]  in_rd_64;
  logic [1:0]  in_reg_in_sel_64;
  logic [2:0]  in_func3_64;
  logic        stall_64, dmem_req_64, dmem_ready_64;
  logic [7:0]  dmem_we_64;
  logic [31:0] dmem_addr_64;
  logic [63:0] dmem_wdata_64, dmem_rdata_64;
  logic        wb_valid_64, wb_mem_reg_64, wb_reg_wr_64, exc_misalign_64, exc_bus_64;
  logic [63:0] wb_alu_out_64, wb_data_64, wb_pc_imm_64, wb_imm_64;
  logic [4:0]  wb_rd_64;
  logic [1:0]  wb_reg_in_sel_64;

  int checks   = 0;
  int failures = 0;
  int n_req;

  mem_stage_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_out(in_alu_out),
    .in_rv2(in_rv2), .in_pc_imm(in_pc_imm), .in_imm(in_imm), .in_rd(in_rd),
    .in_reg_in_sel(in_reg_in_sel), .in_func3(in_func3), .in_is_load(in_is_load),
    .in_is_store(in_is_store), .in_reg_wr(in_reg_wr), .flush(flush), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_alu_out(wb_alu_out), .wb_data(wb_data),
    .wb_pc_imm(wb_pc_imm), .wb_imm(wb_imm), .wb_rd(wb_rd),
    .wb_reg_in_sel(wb_reg_in_sel), .wb_mem_reg(wb_mem_reg), .wb_reg_wr(wb_reg_wr),
    .exc_misalign(exc_misalign), .exc_bus(exc_bus)
  );

  mem_stage_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT(15)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_64), .in_alu_out(in_alu_out_64),
    .in_rv2(in_rv2_64), .in_pc_imm(in_pc_imm_64), .in_imm(in_imm_64), .in_rd(in_rd_64),
    .in_reg_in_sel(in_reg_in_sel_64), .in_func3(in_func3_64), .in_is_load(in_is_load_64),
    .in_is_store(in_is_store_64), .in_reg_wr(in_reg_wr_64), .flush(flush_64),
    .stall(stall_64), .dmem_req(dmem_req_64), .dmem_we(dmem_we_64),
    .dmem_addr(dmem_addr_64), .dmem_wdata(dmem_wdata_64), .dmem_ready(dmem_ready_64),
    .dmem_rdata(dmem_rdata_64), .wb_valid(wb_valid_64), .wb_alu_out(wb_alu_out_64),
    .wb_data(wb_data_64), .wb_pc_imm(wb_pc_imm_64), .wb_imm(wb_imm_64),
    .wb_rd(wb_rd_64), .wb_reg_in_sel(wb_reg_in_sel_64), .wb_mem_reg(wb_mem_reg_64),
    .wb_reg_wr(wb_reg_wr_64), .exc_misalign(exc_misalign_64), .exc_bus(exc_bus_64)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_alu_out = 32'd0; in_rv2 = 32'd0; in_pc_imm = 32'd0;
    in_imm = 32'd0; in_rd = 5'd0; in_reg_in_sel = 2'd0; in_func3 = 3'd0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_reg_wr = 1'b0; flush = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic idle_in64();
    in_valid_64 = 1'b0; in_alu_out_64 = 64'd0; in_rv2_64 = 64'd0; in_pc_imm_64 = 64'd0;
    in_imm_64 = 64'd0; in_rd_64 = 5'd0; in_reg_in_sel_64 = 2'd0; in_func3_64 = 3'd0;
    in_is_load_64 = 1'b0; in_is_store_64 = 1'b0; in_reg_wr_64 = 1'b0; flush_64 = 1'b0;
    dmem_ready_64 = 1'b0; dmem_rdata_64 = 64'd0;
  endtask

  task automatic op(input logic [31:0] addr, input logic [31:0] rv2, input logic [2:0] f3,
                    input logic ld, input logic st, input logic [4:0] rd);
    in_valid = 1'b1; in_alu_out = addr; in_rv2 = rv2; in_func3 = f3;
    in_is_load = ld; in_is_store = st; in_reg_wr = 1'b1; in_rd = rd;
    in_pc_imm = addr + 32'h0000_1000; in_imm = 32'h0000_0040; in_reg_in_sel = 2'b01;
  endtask

  task automatic op64(input logic [63:0] addr, input logic [63:0] rv2, input logic [2:0] f3,
                      input logic ld, input logic st);
    in_valid_64 = 1'b1; in_alu_out_64 = addr; in_rv2_64 = rv2; in_func3_64 = f3;
    in_is_load_64 = ld; in_is_store_64 = st; in_reg_wr_64 = 1'b1; in_rd_64 = 5'd3;
    in_pc_imm_64 = 64'd0; in_imm_64 = 64'd0; in_reg_in_sel_64 = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    idle_in64();
    // an aligned load held at the inputs must not leak a request during reset
    in_valid = 1'b1; in_is_load = 1'b1; in_func3 = 3'b010;
    #3;
    check("rst_req", dmem_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_exc", {exc_misalign, exc_bus}, 2'b00);
    idle_in();
    step(); step();
    rst_n = 1'b1;
    step();

    // SB to offset 3, ready in the same cycle
    op(32'h0000_0103, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 5'd5);
    dmem_ready = 1'b1;
    #1;
    check("sb_req", dmem_req, 1'b1);
    check("sb_we", dmem_we, 4'b1000);
    check("sb_wdata", dmem_wdata, 32'hAB00_0000);
    check("sb_addr", dmem_addr, 32'h0000_0100);
    check("sb_stall", stall, 1'b0);
    step(); idle_in(); #1;
    check("sb_wb_valid", wb_valid, 1'b1);
    check("sb_wb_reg_wr", wb_reg_wr, 1'b0);
    check("sb_wb_alu", wb_alu_out, 32'h0000_0103);
    check("sb_wb_pc_imm", wb_pc_imm, 32'h0000_1103);
    check("sb_wb_rd_sel", {wb_rd, wb_reg_in_sel, wb_mem_reg}, {5'd5, 2'b01, 1'b0});

    // LH at offset 2, ready on the fourth cycle; upstream garbage while waiting
    op(32'h0000_0202, 32'd0, 3'b001, 1'b1, 1'b0, 5'd7);
    #1;
    check("lh_c0_req", dmem_req, 1'b1);
    check("lh_c0_addr", dmem_addr, 32'h0000_0200);
    check("lh_c0_we", dmem_we, 4'b0000);
    check("lh_c0_stall", stall, 1'b1);
    step();
    idle_in(); in_valid = 1'b1; in_is_store = 1'b1; in_alu_out = 32'h0000_FFF0; in_rv2 = 32'hFFFF_FFFF;
    #1;
    check("lh_c1_stall", stall, 1'b1);
    check("lh_c1_addr", dmem_addr, 32'h0000_0200);
    check("lh_c1_we", dmem_we, 4'b0000);
    step(); #1;
    check("lh_c2_stall", stall, 1'b1);
    step();
    dmem_ready = 1'b1; dmem_rdata = 32'h8001_1234;
    #1;
    check("lh_c3_stall", stall, 1'b0);
    check("lh_c3_req", dmem_req, 1'b1);
    step(); idle_in(); #1;
    check("lh_wb_valid", wb_valid, 1'b1);
    check("lh_wb_data", wb_data, 32'hFFFF_8001);
    check("lh_wb_reg_wr", wb_reg_wr, 1'b1);
    check("lh_wb_mem_reg", wb_mem_reg, 1'b1);
    check("lh_wb_rd_alu", {wb_rd, wb_alu_out}, {5'd7, 32'h0000_0202});
    check("lh_req_after", dmem_req, 1'b0);

    // LHU, same data, ready same cycle
    op(32'h0000_0202, 32'd0, 3'b101, 1'b1, 1'b0, 5'd8);
    dmem_ready = 1'b1; dmem_rdata = 32'h8001_1234;
    step(); idle_in(); #1;
    check("lhu_wb_data", wb_data, 32'h0000_8001);
    check("lhu_wb_reg_wr", wb_reg_wr, 1'b1);

    // LB at offset 1, sign-extended
    op(32'h0000_0601, 32'd0, 3'b000, 1'b1, 1'b0, 5'd4);
    dmem_ready = 1'b1; dmem_rdata = 32'h1122_F344;
    step(); idle_in(); #1;
    check("lb_wb_data", wb_data, 32'hFFFF_FFF3);

    // LW at 0x101 is misaligned
    op(32'h0000_0101, 32'd0, 3'b010, 1'b1, 1'b0, 5'd9);
    #1;
    check("mis_req", dmem_req, 1'b0);
    check("mis_stall", stall, 1'b0);
    step(); idle_in(); #1;
    check("mis_exc", exc_misalign, 1'b1);
    check("mis_wb_valid", wb_valid, 1'b1);
    check("mis_wb_reg_wr", wb_reg_wr, 1'b0);
    step(); #1;
    check("mis_exc_pulse", exc_misalign, 1'b0);

    // SW with no ready: timeout after TIMEOUT=4 request cycles
    op(32'h0000_0040, 32'h1234_5678, 3'b010, 1'b0, 1'b1, 5'd3);
    #1;
    n_req = 0;
    for (int i = 0; i < 20; i++) begin
      if (dmem_req !== 1'b1) break;
      n_req++;
      step(); idle_in(); #1;
    end
    check("to_req_cycles", n_req, 4);
    check("to_stall_released", stall, 1'b0);
    step(); #1;
    check("to_exc_bus", exc_bus, 1'b1);
    check("to_wb_valid", wb_valid, 1'b1);
    check("to_wb_reg_wr", wb_reg_wr, 1'b0);
    step(); #1;
    check("to_exc_pulse", exc_bus, 1'b0);
    check("to_idle_stall", stall, 1'b0);

    // flush while waiting: the load completes but the slot is a bubble
    op(32'h0000_0300, 32'd0, 3'b010, 1'b1, 1'b0, 5'd10);
    step(); idle_in(); flush = 1'b1; #1;
    check("fw_req_held", dmem_req, 1'b1);
    step(); flush = 1'b0;
    step(); dmem_ready = 1'b1; dmem_rdata = 32'h0000_0055; #1;
    check("fw_req", dmem_req, 1'b1);
    check("fw_stall", stall, 1'b0);
    step(); idle_in(); #1;
    check("fw_wb_valid", wb_valid, 1'b0);
    check("fw_wb_reg_wr", wb_reg_wr, 1'b0);

    // flush in IDLE suppresses the request
    op(32'h0000_0304, 32'h0000_0001, 3'b010, 1'b0, 1'b1, 5'd2);
    flush = 1'b1; #1;
    check("fi_req", dmem_req, 1'b0);
    check("fi_stall", stall, 1'b0);
    step(); idle_in(); #1;
    check("fi_wb_valid", wb_valid, 1'b0);

    // reset while waiting drops the request and clears outputs at once
    op(32'h0000_0400, 32'd0, 3'b010, 1'b1, 1'b0, 5'd11);
    step(); idle_in(); #1;
    check("rw_req_before", dmem_req, 1'b1);
    check("rw_alu_before", wb_alu_out, 32'h0000_0400);
    rst_n = 1'b0; #1;
    check("rw_req", dmem_req, 1'b0);
    check("rw_stall", stall, 1'b0);
    check("rw_alu", wb_alu_out, 32'h0000_0000);
    step(); rst_n = 1'b1;
    step();
    op(32'h0000_0500, 32'h0000_0011, 3'b000, 1'b0, 1'b1, 5'd1);
    dmem_ready = 1'b1; #1;
    check("rw_idle_stall", stall, 1'b0);
    check("rw_idle_we", dmem_we, 4'b0001);
    step(); idle_in();

    // 64-bit datapath: word loads from the upper half
    op64(64'h0000_000C, 64'd0, 3'b110, 1'b1, 1'b0);
    dmem_ready_64 = 1'b1; dmem_rdata_64 = 64'hDEAD_BEEF_0000_0000; #1;
    check("d_lwu_addr", dmem_addr_64, 32'h0000_0008);
    check("d_lwu_we", dmem_we_64, 8'h00);
    step(); idle_in64(); #1;
    check("d_lwu_data", wb_data_64, 64'h0000_0000_DEAD_BEEF);
    op64(64'h0000_000C, 64'd0, 3'b010, 1'b1, 1'b0);
    dmem_ready_64 = 1'b1; dmem_rdata_64 = 64'hDEAD_BEEF_0000_0000;
    step(); idle_in64(); #1;
    check("d_lw_data", wb_data_64, 64'hFFFF_FFFF_DEAD_BEEF);
    op64(64'h0000_000C, 64'h0000_0000_1234_5678, 3'b010, 1'b0, 1'b1);
    dmem_ready_64 = 1'b1; #1;
    check("d_sw_we", dmem_we_64, 8'hF0);
    check("d_sw_wdata", dmem_wdata_64, 64'h1234_5678_0000_0000);
    step(); idle_in64();
    op64(64'h0000_000C, 64'd0, 3'b011, 1'b1, 1'b0); #1;
    check("d_ld_mis_req", dmem_req_64, 1'b0);
    step(); idle_in64(); #1;
    check("d_ld_mis_exc", exc_misalign_64, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
